// File: rtl/ysyx_220066_memrd_arb.sv
// ysyx_220066_memrd_arb: shares the single 64-bit memory read port between
// instruction fetch and data read, with at most one read outstanding.
// Optional feature macro: YSYX_220066_ARB_RR_EN enables round-robin on contention.
// Without it, data has fixed priority over fetch.
module ysyx_220066_memrd_arb #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  // fetch side
  input  logic          if_req,
  input  logic [AW-1:0] if_pc,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_instr,
  output logic          if_error,
  // data side
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_error,
  // downstream read port
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rerror
);

  typedef enum logic [1:0] {StIdle, StWaitI, StWaitD} state_e;

  state_e state_q;
  logic   owner_pc2_q;  // if_pc[2] of the fetch in flight: selects upper/lower word
  logic   drop_q;       // fetch in flight was flushed; swallow its response

  logic   in_idle;
  logic   prio_d;       // data wins a contended cycle
  logic   sel_d;        // data is the current winner
  logic   issue;
  logic   rsp_i;
  logic   rsp_d;

  // Byte-in-word bits of the fetch PC carry no information (4-byte aligned).
  logic   unused_pc_bits;
  assign unused_pc_bits = ^if_pc[1:0];

`ifdef YSYX_220066_ARB_RR_EN
  logic last_q;  // 1: data won the last grant, 0: fetch did
  assign prio_d = ~last_q;
`else
  assign prio_d = 1'b1;
`endif

  // Combinational arbitration and downstream request, only while idle.
  always_comb begin
    in_idle  = (state_q == StIdle) && !rst;
    sel_d    = d_req & (~if_req | prio_d);
    mem_req  = in_idle & (if_req | d_req);
    mem_addr = '0;
    if (mem_req) begin
      mem_addr = sel_d ? d_addr : {if_pc[AW-1:3], 3'b000};
    end
    issue  = mem_req & mem_gnt;
    if_gnt = issue & ~sel_d;
    d_gnt  = issue & sel_d;
  end

  // Response steering; outputs read zero unless their valid is high.
  always_comb begin
    rsp_i     = !rst && (state_q == StWaitI) && mem_rvalid;
    rsp_d     = !rst && (state_q == StWaitD) && mem_rvalid;
    if_rvalid = rsp_i & ~drop_q & ~if_flush;
    if_instr  = '0;
    if (if_rvalid) begin
      if_instr = owner_pc2_q ? mem_rdata[63:32] : mem_rdata[31:0];
    end
    if_error  = if_rvalid & mem_rerror;
    d_rvalid  = rsp_d;
    d_rdata   = rsp_d ? mem_rdata : '0;
    d_error   = rsp_d & mem_rerror;
  end

  // Transaction FSM plus fetch bookkeeping; one read outstanding at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_pc2_q <= 1'b0;
      drop_q      <= 1'b0;
`ifdef YSYX_220066_ARB_RR_EN
      last_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue) begin
`ifdef YSYX_220066_ARB_RR_EN
            last_q <= sel_d;
`endif
            if (sel_d) begin
              state_q <= StWaitD;
            end else begin
              state_q     <= StWaitI;
              owner_pc2_q <= if_pc[2];
              drop_q      <= 1'b0;
            end
          end
        end
        StWaitI: begin
          if (mem_rvalid) begin
            state_q <= StIdle;
          end else if (if_flush) begin
            drop_q <= 1'b1;
          end
        end
        StWaitD: begin
          // A flush never cancels a data read.
          if (mem_rvalid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
